// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types, constants and the shift-based volume scaler for audio_out
//
// Purpose: volume encoding, soft-volume gain targets (Q6) and sample width
//          shared by audio_if, audio_nco and audio_out.
// Contents:
//   SAMPLE_W     - audio sample width (16)
//   vol_t        - 2-bit OSD volume setting
//   GAIN_Q6      - Q6 gain targets per volume step, used when AUDIO_SOFT_VOL_EN is defined
//   scale_shift  - arithmetic shift scaler used when AUDIO_SOFT_VOL_EN is undefined
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    VOL_MUTE    = 2'd0,
    VOL_QUARTER = 2'd1,
    VOL_HALF    = 2'd2,
    VOL_UNITY   = 2'd3
  } vol_t;

  // Q6 targets; chosen so that x*g>>>6 matches the shift scaler bit-exactly.
  localparam logic [6:0] GAIN_Q6 [4] = '{7'd0, 7'd16, 7'd32, 7'd64};

  function automatic logic signed [SAMPLE_W-1:0] scale_shift(
    input logic signed [SAMPLE_W-1:0] x,
    input vol_t                       vol
  );
    case (vol)
      VOL_MUTE:    scale_shift = '0;
      VOL_QUARTER: scale_shift = x >>> 2;
      VOL_HALF:    scale_shift = x >>> 1;
      default:     scale_shift = x;
    endcase
  endfunction

endpackage

// File: rtl/audio_if.sv
// rtl/audio_if.sv - sample/volume input bundle and HDMI-side audio outputs of audio_out
//
// Purpose: groups the core-side sample strobe, stereo samples and volume with the
//          packetizer-side audio clock, tick and sample word.
// Signals:
//   sample_stb        - one-cycle pulse, audio_l_in/audio_r_in valid
//   audio_l_in        - signed left sample
//   audio_r_in        - signed right sample
//   volume            - 0 mute, 1 quarter, 2 half, 3 unity
//   clk_audio         - registered 50% duty audio clock
//   sample_tick       - one-cycle pulse on each clk_audio rise
//   audio_sample_word - {left, right} scaled sample
// Modports: master = core/packetizer side, slave = audio_out.
interface audio_if;
  import audio_pkg::*;

  logic                       sample_stb;
  logic signed [SAMPLE_W-1:0] audio_l_in;
  logic signed [SAMPLE_W-1:0] audio_r_in;
  logic [1:0]                 volume;
  logic                       clk_audio;
  logic                       sample_tick;
  logic [2*SAMPLE_W-1:0]      audio_sample_word;

  modport master (
    output sample_stb, audio_l_in, audio_r_in, volume,
    input  clk_audio, sample_tick, audio_sample_word
  );

  modport slave (
    input  sample_stb, audio_l_in, audio_r_in, volume,
    output clk_audio, sample_tick, audio_sample_word
  );

endinterface

// File: rtl/audio_nco.sv
// rtl/audio_nco.sv - fractional phase accumulator deriving the audio clock from clk
//
// Purpose: toggles clk_audio whenever acc + 2*RATE_HZ reaches CLK_HZ, so the long-run
//          audio rate is exactly RATE_HZ with no drift.
// Parameters: CLK_HZ (clk frequency), RATE_HZ (audio sample rate).
// Ports:
//   clk       in  - pixel clock
//   reset     in  - asynchronous, active-high
//   clk_audio out - registered audio clock
//   rise      out - combinational: clk_audio goes 0->1 at the coming clk edge
//   fall      out - combinational: clk_audio goes 1->0 at the coming clk edge
module audio_nco #(
  parameter int CLK_HZ  = 32000000,
  parameter int RATE_HZ = 48000
) (
  input  logic clk,
  input  logic reset,
  output logic clk_audio,
  output logic rise,
  output logic fall
);

  localparam int INC   = 2 * RATE_HZ;
  localparam int ACC_W = $clog2(CLK_HZ + INC);
  localparam logic [ACC_W-1:0] INC_W = ACC_W'(INC);
  localparam logic [ACC_W-1:0] LIM_W = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt;
  logic             wrap;

  // acc stays below CLK_HZ, so acc + INC always fits in ACC_W bits.
  always_comb begin
    nxt  = acc + INC_W;
    wrap = (nxt >= LIM_W);
    rise = wrap & ~clk_audio;
    fall = wrap & clk_audio;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc       <= '0;
      clk_audio <= 1'b0;
    end else begin
      acc <= wrap ? (nxt - LIM_W) : nxt;
      if (wrap) begin
        clk_audio <= ~clk_audio;
      end
    end
  end

endmodule

// File: rtl/audio_out.sv
// rtl/audio_out.sv - audio output stage: 48 kHz clock, sample hold, volume, HDMI sample word
//
// Purpose: holds the latest stereo sample from the mixer, scales it by the OSD volume
//          and refreshes audio_sample_word on each clk_audio falling toggle, so the
//          word is stable for a half period before every rising edge.
// Parameters: CLK_HZ (clk frequency), RATE_HZ (audio sample rate).
// Ports:
//   clk   in  - pixel clock, the only clock
//   reset in  - asynchronous, active-high
//   bus   audio_if.slave - sample/volume inputs, clk_audio/sample_tick/word outputs
// Build option: AUDIO_SOFT_VOL_EN - replace the shift scaler with a Q6 gain that ramps
//               one step per word update toward the volume target.
module audio_out
  import audio_pkg::*;
#(
  parameter int CLK_HZ  = 32000000,
  parameter int RATE_HZ = 48000
) (
  input logic    clk,
  input logic    reset,
  audio_if.slave bus
);

  logic clk_audio;
  logic rise;
  logic fall;

  audio_nco #(
    .CLK_HZ  (CLK_HZ),
    .RATE_HZ (RATE_HZ)
  ) u_nco (
    .clk       (clk),
    .reset     (reset),
    .clk_audio (clk_audio),
    .rise      (rise),
    .fall      (fall)
  );

  logic signed [SAMPLE_W-1:0] hold_l;
  logic signed [SAMPLE_W-1:0] hold_r;
  logic signed [SAMPLE_W-1:0] scaled_l;
  logic signed [SAMPLE_W-1:0] scaled_r;
  logic                       sample_tick;
  logic [2*SAMPLE_W-1:0]      word;

  // Zero-order hold; a strobe coinciding with a word update lands one update later
  // because the word samples the old hold value at that same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_l <= '0;
      hold_r <= '0;
    end else if (bus.sample_stb) begin
      hold_l <= bus.audio_l_in;
      hold_r <= bus.audio_r_in;
    end
  end

`ifdef AUDIO_SOFT_VOL_EN
  logic [6:0] gain;
  logic [6:0] gain_nxt;
  logic [6:0] target;

  function automatic logic signed [SAMPLE_W-1:0] scale_gain(
    input logic signed [SAMPLE_W-1:0] x,
    input logic [6:0]                 g
  );
    logic signed [22:0] p;
    p = x * $signed({1'b0, g});
    return SAMPLE_W'(p >>> 6);
  endfunction

  // The stepped gain is used by the same update that steps it.
  always_comb begin
    target   = GAIN_Q6[bus.volume];
    gain_nxt = gain;
    if (gain < target) begin
      gain_nxt = gain + 7'd1;
    end else if (gain > target) begin
      gain_nxt = gain - 7'd1;
    end
    scaled_l = scale_gain(hold_l, gain_nxt);
    scaled_r = scale_gain(hold_r, gain_nxt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gain <= '0;
    end else if (fall) begin
      gain <= gain_nxt;
    end
  end
`else
  always_comb begin
    scaled_l = scale_shift(hold_l, vol_t'(bus.volume));
    scaled_r = scale_shift(hold_r, vol_t'(bus.volume));
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_tick <= 1'b0;
      word        <= '0;
    end else begin
      sample_tick <= rise;
      if (fall) begin
        word <= {scaled_l, scaled_r};
      end
    end
  end

  assign bus.clk_audio         = clk_audio;
  assign bus.sample_tick       = sample_tick;
  assign bus.audio_sample_word = word;

endmodule
